// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
package unified_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT_F = 2'd1,
      WAIT_D = 2'd2
   } Arb_State_Case;

   typedef enum logic {
      OWNER_FETCH = 1'b0,
      OWNER_DATA  = 1'b1
   } Mem_Owner_Case;

endpackage

// File: rtl/unified_mem_arbiter.sv
// Arbitrates the single-ported unified memory between fetch and load/store, one transaction outstanding.
// Define UMA_FAIR_EN to alternate between requesters on contention instead of fixed data-over-fetch priority.
module unified_mem_arbiter
   import unified_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                spurious_rsp
);

   localparam int BE_W  = DATA_W / 8;
   localparam int OFF_W = $clog2(BE_W);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << OFF_W) - 1);

   Arb_State_Case state;
   logic          spurious_q;
   logic          sel_d;
   logic          sel_f;
   logic          idle;
   logic          grant;

`ifdef UMA_FAIR_EN
   Mem_Owner_Case last_owner;
`endif

   always_comb begin
      sel_d = d_req;
`ifdef UMA_FAIR_EN
      if (d_req && if_req) begin
         sel_d = (last_owner == OWNER_FETCH);
      end
`endif
      sel_f = if_req && !sel_d;
   end

   // Gating with rst_n keeps every combinational output at 0 while reset is held.
   assign idle  = rst_n && (state == IDLE);
   assign grant = idle && (if_req || d_req) && mem_gnt;

   always_comb begin
      mem_req   = idle && (if_req || d_req);
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = '0;
      if (mem_req) begin
         if (sel_d) begin
            mem_we    = d_we;
            mem_addr  = d_addr & ALIGN_MASK;
            mem_wdata = d_wdata;
            mem_be    = d_be;
         end else begin
            mem_addr  = if_addr & ALIGN_MASK;
            mem_be    = '1;
         end
      end
   end

   always_comb begin
      if_gnt    = idle && sel_f && mem_gnt;
      d_gnt     = idle && sel_d && mem_gnt;
      if_rvalid = rst_n && (state == WAIT_F) && mem_rvalid;
      d_rvalid  = rst_n && (state == WAIT_D) && mem_rvalid;
      if_rdata  = if_rvalid ? mem_rdata : '0;
      d_rdata   = d_rvalid  ? mem_rdata : '0;
   end

   assign spurious_rsp = spurious_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         spurious_q <= 1'b0;
`ifdef UMA_FAIR_EN
         last_owner <= OWNER_FETCH;
`endif
      end else begin
         case (state)
            IDLE: begin
               // A response with nothing outstanding (even alongside a grant) is never routed.
               if (mem_rvalid) begin
                  spurious_q <= 1'b1;
               end
               if (grant) begin
                  state <= sel_d ? WAIT_D : WAIT_F;
`ifdef UMA_FAIR_EN
                  last_owner <= sel_d ? OWNER_DATA : OWNER_FETCH;
`endif
               end
            end
            WAIT_F, WAIT_D: begin
               if (mem_rvalid) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed scenarios then randomized traffic vs a behavioural model.
// Build with UMA_FAIR_EN defined to check the alternating-priority variant.
module tb_unified_mem_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int BE_W   = DATA_W / 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              if_req = 1'b0;
   logic [ADDR_W-1:0] if_addr = '0;
   logic              if_gnt, if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   logic              d_req = 1'b0;
   logic              d_we = 1'b0;
   logic [ADDR_W-1:0] d_addr = '0;
   logic [DATA_W-1:0] d_wdata = '0;
   logic [BE_W-1:0]   d_be = '0;
   logic              d_gnt, d_rvalid;
   logic [DATA_W-1:0] d_rdata;
   logic              mem_req, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [BE_W-1:0]   mem_be;
   logic              mem_gnt = 1'b0;
   logic              mem_rvalid = 1'b0;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic              spurious_rsp;

   always #5 clk = ~clk;

   unified_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .spurious_rsp(spurious_rsp)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Behavioural model: is a transaction outstanding, who owns it, who was served last, spurious seen.
   bit m_busy, m_owner_d, m_last_d, m_spur;
   bit auto_mem, auto_req;
   bit if_wait, d_wait;
   int rsp_cnt;
   logic [31:0] rsp_data;
   logic [31:0] ref_mem [int unsigned];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      int unsigned k;
      k = a >> 2;
      if (ref_mem.exists(k)) return ref_mem[k];
      return {a[15:0], ~a[15:0]};
   endfunction

   function automatic logic [31:0] rand_addr();
      return 32'h0000_2000 + $urandom_range(0, 63);
   endfunction

   task automatic idle_inputs();
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      if_req = 1'b1; d_req = 1'b1; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      #2;
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_be", mem_be, 0);
      check("rst_if_gnt", if_gnt, 0);
      check("rst_d_gnt", d_gnt, 0);
      check("rst_if_rvalid", if_rvalid, 0);
      check("rst_d_rvalid", d_rvalid, 0);
      check("rst_if_rdata", if_rdata, 0);
      check("rst_d_rdata", d_rdata, 0);
      check("rst_spurious", spurious_rsp, 0);
      m_busy = 0; m_owner_d = 0; m_last_d = 0; m_spur = 0;
      rsp_cnt = 0; if_wait = 0; d_wait = 0;
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // One clock: check outputs against the model, advance the model, then optionally drive new random stimulus.
   task automatic cycle();
      bit e_req, e_sel_d, e_ifg, e_dg, e_ifv, e_dv, g, rv;
      logic [31:0] e_addr;
      logic [31:0] g_addr, g_wdata, w;
      logic [3:0]  g_be;
      bit g_we;
      #1;
      e_ifv = 0; e_dv = 0; e_ifg = 0; e_dg = 0; e_req = 0; e_sel_d = 0;
      if (!m_busy) begin
         e_req   = if_req || d_req;
         e_sel_d = d_req;
`ifdef UMA_FAIR_EN
         if (if_req && d_req) e_sel_d = !m_last_d;
`endif
         e_ifg = if_req && !e_sel_d && mem_gnt;
         e_dg  = e_sel_d && mem_gnt;
      end else begin
         e_ifv = mem_rvalid && !m_owner_d;
         e_dv  = mem_rvalid && m_owner_d;
      end
      check("mem_req", mem_req, e_req);
      check("if_gnt", if_gnt, e_ifg);
      check("d_gnt", d_gnt, e_dg);
      check("if_rvalid", if_rvalid, e_ifv);
      check("d_rvalid", d_rvalid, e_dv);
      check("if_rdata", if_rdata, e_ifv ? mem_rdata : 32'h0);
      check("d_rdata", d_rdata, e_dv ? mem_rdata : 32'h0);
      check("spurious_rsp", spurious_rsp, m_spur);
      if (e_req) begin
         e_addr = e_sel_d ? d_addr : if_addr;
         e_addr[1:0] = 2'b00;
         check("mem_addr", mem_addr, e_addr);
         check("mem_we", mem_we, e_sel_d ? d_we : 1'b0);
         check("mem_be", mem_be, e_sel_d ? d_be : 4'hF);
         check("mem_wdata", mem_wdata, e_sel_d ? d_wdata : 32'h0);
      end
      g = e_req && mem_gnt;
      rv = mem_rvalid;
      g_we = e_sel_d && d_we;
      g_addr = e_sel_d ? d_addr : if_addr;
      g_wdata = d_wdata;
      g_be = d_be;
      @(posedge clk);
      if (!m_busy) begin
         if (rv) m_spur = 1;
         if (g) begin
            m_busy = 1; m_owner_d = e_sel_d; m_last_d = e_sel_d;
         end
      end else if (rv) begin
         m_busy = 0;
      end
      #1;
      if (auto_mem) begin
         mem_rvalid = 1'b0;
         mem_rdata = $urandom;
         if (g) begin
            if (g_we) begin
               w = mem_word(g_addr);
               for (int b = 0; b < 4; b++) if (g_be[b]) w[8*b +: 8] = g_wdata[8*b +: 8];
               ref_mem[g_addr >> 2] = w;
               rsp_data = $urandom;
            end else begin
               rsp_data = mem_word(g_addr);
            end
            rsp_cnt = $urandom_range(1, 3);
         end
         if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata = rsp_data;
            end
         end else if (!g && $urandom_range(0, 63) == 0) begin
            mem_rvalid = 1'b1;
         end
         mem_gnt = ($urandom_range(0, 3) != 0);
      end
      if (auto_req) begin
         if (e_ifg) begin if_wait = 1; if_req = 1'b0; end
         if (e_ifv) if_wait = 0;
         if (!if_wait) begin
            if (!if_req) begin
               if ($urandom_range(0, 2) == 0) begin if_req = 1'b1; if_addr = rand_addr(); end
            end else if ($urandom_range(0, 9) == 0) begin
               if_req = 1'b0;
            end
         end
         if (e_dg) begin d_wait = 1; d_req = 1'b0; end
         if (e_dv) d_wait = 0;
         if (!d_wait) begin
            if (!d_req) begin
               if ($urandom_range(0, 2) == 0) begin
                  d_req = 1'b1; d_we = $urandom_range(0, 1); d_addr = rand_addr();
                  d_wdata = $urandom; d_be = $urandom_range(1, 15);
               end
            end else if ($urandom_range(0, 9) == 0) begin
               d_req = 1'b0;
            end
         end
      end
   endtask

   initial begin
      bit first_d;
      auto_mem = 0; auto_req = 0;
      do_reset();

      // Fetch only
      if_req = 1'b1; if_addr = 32'h0000_0104; mem_gnt = 1'b1;
      #1;
      check("t1_mem_addr", mem_addr, 32'h104);
      check("t1_mem_be", mem_be, 4'hF);
      check("t1_if_gnt", if_gnt, 1);
      cycle();
      if_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0010_0093;
      #1;
      check("t1_if_rvalid", if_rvalid, 1);
      check("t1_if_rdata", if_rdata, 32'h0010_0093);
      cycle();
      mem_rvalid = 1'b0;

      // Store
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2003; d_be = 4'b1000; d_wdata = 32'hAB00_0000; mem_gnt = 1'b1;
      #1;
      check("t2_mem_addr", mem_addr, 32'h2000);
      check("t2_mem_be", mem_be, 4'b1000);
      check("t2_mem_we", mem_we, 1);
      check("t2_mem_wdata", mem_wdata, 32'hAB00_0000);
      check("t2_d_gnt", d_gnt, 1);
      cycle();
      d_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0;
      #1;
      check("t2_d_rvalid", d_rvalid, 1);
      check("t2_if_rvalid", if_rvalid, 0);
      cycle();
      mem_rvalid = 1'b0;

      // Contention; last owner is data here
`ifdef UMA_FAIR_EN
      first_d = 0;
`else
      first_d = 1;
`endif
      if_req = 1'b1; if_addr = 32'h300; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h404; d_be = 4'hF;
      mem_gnt = 1'b1;
      #1;
      check("t3_first_d_gnt", d_gnt, first_d);
      check("t3_first_if_gnt", if_gnt, !first_d);
      cycle();
      if (first_d) d_req = 1'b0; else if_req = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
      #1;
      check("t3_wait_if_gnt", if_gnt, 0);
      check("t3_wait_d_gnt", d_gnt, 0);
      cycle();
      mem_rvalid = 1'b0;
      #1;
      check("t3_second_d_gnt", d_gnt, !first_d);
      check("t3_second_if_gnt", if_gnt, first_d);
      cycle();
      if_req = 1'b0; d_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h2222_2222;
      cycle();
      mem_rvalid = 1'b0;

      // Backpressure
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h508; d_be = 4'hF; mem_gnt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("t4_bp_mem_req", mem_req, 1);
         check("t4_bp_mem_addr", mem_addr, 32'h508);
         check("t4_bp_d_gnt", d_gnt, 0);
         cycle();
      end
      mem_gnt = 1'b1;
      #1;
      check("t4_d_gnt", d_gnt, 1);
      cycle();
      d_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h3333_3333;
      cycle();
      mem_rvalid = 1'b0;

      // Grant and stray response in the same IDLE cycle
      if_req = 1'b1; if_addr = 32'h600; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h4444_4444;
      #1;
      check("t5_if_gnt", if_gnt, 1);
      check("t5_if_rvalid", if_rvalid, 0);
      cycle();
      if_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
      #1;
      check("t5_spurious", spurious_rsp, 1);
      check("t5_if_rvalid_real", if_rvalid, 1);
      cycle();
      mem_rvalid = 1'b0;

      // Reset in the middle of a store
      do_reset();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h700; d_be = 4'hF; d_wdata = 32'h6666_6666; mem_gnt = 1'b1;
      cycle();
      d_req = 1'b0; mem_gnt = 1'b0;
      cycle();
      do_reset();
      mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
      #1;
      check("t6_late_d_rvalid", d_rvalid, 0);
      cycle();
      mem_rvalid = 1'b0;
      cycle();
      cycle();
      check("t6_spurious_sticky", spurious_rsp, 1);

      // Randomized traffic
      do_reset();
      auto_mem = 1; auto_req = 1;
      repeat (3000) cycle();
      auto_mem = 0; auto_req = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
